// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO, busy counter and stall request.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (ops 9-12).
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_we;

    logic        is_mul;
    logic        is_div;
    logic        is_mac;
    logic        accept;
    logic        last;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic        div_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [63:0] res;
    logic        res_we;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_mac = (op >= OP_MADD) && (op <= OP_MSUBU);
`else
        is_mac = 1'b0;
`endif
        accept = start && (state == IDLE) && (is_mul || is_div || is_mac);
        last   = (state == RUN) && (counter == 4'd1);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (counter == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Sign-extended 64-bit operands give the exact signed product mod 2^64.
    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    assign acc    = {hi, lo};

    // One unsigned divider serves both forms; signed div runs on magnitudes.
    always_comb begin
        div_zero = (rt_data == 32'd0);
        abs_a    = rs_data[31] ? -rs_data : rs_data;
        abs_b    = rt_data[31] ? -rt_data : rt_data;
        dvd      = (op == OP_DIV) ? abs_a : rs_data;
        dvs      = (op == OP_DIV) ? abs_b : rt_data;
        if (div_zero) dvs = 32'd1;
        uq       = dvd / dvs;
        ur       = dvd % dvs;
    end

    always_comb begin
        res    = 64'd0;
        res_we = 1'b1;
        unique case (1'b1)
            (op == OP_MULT):  res = prod_s;
            (op == OP_MULTU): res = prod_u;
            (op == OP_DIV): begin
                res[31:0]  = (rs_data[31] ^ rt_data[31]) ? -uq : uq;
                res[63:32] = rs_data[31] ? -ur : ur;
                res_we     = !div_zero;
            end
            (op == OP_DIVU): begin
                res    = {ur, uq};
                res_we = !div_zero;
            end
`ifdef MDU_MADD_EN
            (op == OP_MADD):  res = acc + prod_s;
            (op == OP_MADDU): res = acc + prod_u;
            (op == OP_MSUB):  res = acc - prod_s;
            (op == OP_MSUBU): res = acc - prod_u;
`endif
            default: begin
                res    = 64'd0;
                res_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else if (accept) begin
            counter <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            pend_we <= res_we;
        end else if (state == RUN) begin
            counter <= counter - 4'd1;
        end
    end

    // Divide-by-zero keeps HI/LO by clearing pend_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (last) begin
            if (pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (state == IDLE) begin
            if (op == OP_MTHI) hi <= rs_data;
            if (op == OP_MTLO) lo <= rs_data;
        end
    end

    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI) out = hi;
        if (op == OP_MFLO) out = lo;
    end

    assign busy      = (state == RUN);
    assign stall_req = busy | start;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, located in the execute stage.
- Takes the two forwarded register-file read operands (rs, rt) and performs MIPS mult/multu/div/divu, mfhi/mflo, and mthi/mtlo.
- Models realistic latency through a busy counter. The hazard unit stalls dependent instructions in decode while busy or start is high.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, number of busy cycles for div/divu (1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- rs_data  input  32  operand A (forwarded rs value)
- rt_data  input  32  operand B (forwarded rt value)
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu
- start  input  1  one-cycle pulse accompanying ops 1-4 and 9-12
- busy  output  1  high while an operation is in flight
- stall_req  output  1  busy | start; consumed by the hazard unit
- out  output  32  hi for op 5, lo for op 6, otherwise 0

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - hi, lo, counter, pending results and busy all go to 0 immediately.
  - Any operation in flight is discarded.
- Accepting an operation:
  - On a clock edge with start=1, busy=0 and op in {1-4}, operands are latched and the result is computed into pending registers.
  - counter is loaded with MULT_CYCLES (ops 1-2) or DIV_CYCLES (ops 3-4).
  - busy rises in the cycle after the start edge.
- Counting and commit:
  - Each edge with busy=1 decrements counter.
  - On the edge where counter goes 1->0, pending values commit to hi/lo and busy falls.
  - Net effect: busy is high for exactly N cycles, and hi/lo are visible in the first cycle after busy drops.
- Ignored starts:
  - start while busy=1: ignored, with no effect on the current operation.
  - start with an op outside the accepted set: ignored.
- Arithmetic:
  - mult: {hi,lo} = signed 32x32 -> 64-bit product.
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt_data = 0): operation still runs the full DIV_CYCLES busy period; hi and lo stay unchanged at commit.
- mthi/mtlo:
  - Write rs_data into hi/lo on the clock edge when busy=0.
  - Ignored while busy=1 (the hazard unit guarantees this does not occur).
- mfhi/mflo:
  - out is combinational from the hi/lo registers.
  - While busy=1, out shows the old hi/lo (the stall prevents consumption).
- Hold and reset values:
  - With op=0 and start=0, all state holds.
  - Outputs after reset: busy=0, stall_req=start, out=0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 9-12 accepted with start and take MULT_CYCLES.
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} -= signed product.
  - msubu: {hi,lo} -= unsigned product.
  - Arithmetic is modulo 2^64.
  - The accumulate base is the hi/lo value at the start edge.
- Undefined: ops 9-12 behave as op 0, and start with them is ignored (busy stays 0).

Test Plan:
- Reset, then mthi with rs=0x12345678 and mtlo with rs=0x9ABCDEF0; mfhi/mflo -> out=0x12345678 / 0x9ABCDEF0.
- mult 0xFFFFFFFE x 3 with start pulse -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div -7 / 2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 -> lo=14, hi=2. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- div 5 / 0 with hi=0xAA, lo=0xBB preset -> busy 10 cycles; hi=0xAA, lo=0xBB unchanged.
- Start a second mult at busy cycle 2 of a div -> ignored; div results commit at cycle 10. Assert reset asynchronously at busy cycle 3 -> busy, hi, lo read 0 before the next clock edge.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu 1 x 1 -> hi=1, lo=0. Without the macro: same stimulus -> busy stays 0 and hi/lo are unchanged.
